// File: rtl/pe_pkg.sv
// Shared constants, FSM state encoding and a default-width round/saturate
// helper for the output-stationary PE family.
package pe_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 8;
  localparam int ACC_W_DEF  = 36;

  localparam int SUM_W_DEF = ACC_W_DEF + 1;
  localparam int SH_W_DEF  = SUM_W_DEF - FRAC_W_DEF;
  localparam logic [SUM_W_DEF-1:0] HALF_DEF = SUM_W_DEF'(1) << (FRAC_W_DEF - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pe_state_t;

  // Returns {saturated, q}: round half up, then clamp to the DATA_W range.
  function automatic logic [DATA_W_DEF:0] sat_round(input logic [ACC_W_DEF-1:0] acc,
                                                    input logic sgn);
    logic [SUM_W_DEF-1:0]             sum;
    logic [SH_W_DEF-1:0]              sh;
    logic [SH_W_DEF-DATA_W_DEF:0]     top;
    sum = {sgn & acc[ACC_W_DEF-1], acc} + HALF_DEF;
    sh  = sum[SUM_W_DEF-1:FRAC_W_DEF];
    top = sh[SH_W_DEF-1:DATA_W_DEF-1];
    if (sgn && top != '0 && top != '1)
      return {1'b1, sh[SH_W_DEF-1], {(DATA_W_DEF-1){~sh[SH_W_DEF-1]}}};
    if (!sgn && top[SH_W_DEF-DATA_W_DEF:1] != '0)
      return {1'b1, {DATA_W_DEF{1'b1}}};
    return {1'b0, sh[DATA_W_DEF-1:0]};
  endfunction
endpackage

// File: rtl/pe_os_q_if.sv
// Data/valid link between neighbouring PEs; used for the activation,
// weight and result-drain paths.
interface pe_os_q_if
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] data;
  logic              valid;

  modport master (output data, valid);
  modport slave  (input  data, valid);
endinterface

// File: rtl/pe_os_q_requant.sv
// Combinational fixed-point requantiser: round half up by FRAC_W bits and
// saturate into DATA_W, signed or unsigned.
module pe_requant
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] q,
  output logic              sat
);
  localparam int SUM_W = ACC_W + 1;
  localparam int SH_W  = SUM_W - FRAC_W;
  localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC_W - 1);

  logic [SUM_W-1:0]       sum;
  logic [SH_W-1:0]        sh;
  logic [SH_W-DATA_W:0]   top;

  // One extra bit keeps the rounding add from wrapping.
  always_comb begin
    sum = {SIGNED & acc[ACC_W-1], acc} + HALF;
    sh  = sum[SUM_W-1:FRAC_W];
    top = sh[SH_W-1:DATA_W-1];
    q   = sh[DATA_W-1:0];
    sat = 1'b0;
    if (SIGNED) begin
      if (top != '0 && top != '1) begin
        sat = 1'b1;
        q   = {sh[SH_W-1], {(DATA_W-1){~sh[SH_W-1]}}};
      end
    end else if (top[SH_W-DATA_W:1] != '0) begin
      sat = 1'b1;
      q   = '1;
    end
  end
endmodule

// File: rtl/pe_os_q.sv
// Output-stationary systolic PE: MAC with first/last framing, requantised
// double-buffered result, and a one-register-per-row drain chain.
module pe_os_q
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  pe_os_q_if.slave  act_in,
  input  logic      first_in,
  input  logic      last_in,
  pe_os_q_if.master act_out,
  output logic      first_out,
  output logic      last_out,
  pe_os_q_if.slave  w_in,
  pe_os_q_if.master w_out,
  input  logic      drain,
  pe_os_q_if.slave  res_in,
  pe_os_q_if.master res_out,
  output logic      done,
  output logic      ovf,
  output logic      err
);
  // state   | meaning
  // ST_IDLE | no dot product open; waiting for a first beat
  // ST_ACC  | dot product open; accumulating until the last beat

  pe_state_t           state, state_nxt;
  logic [2*DATA_W-1:0] ax, wx, prod;
  logic [ACC_W-1:0]    prod_ext, base, acc, acc_nxt;
  logic [ACC_W:0]      sum;
  logic [DATA_W-1:0]   q, held, sh;
  logic                fire, capture, acc_ovf, sat, held_v, sh_v, done_q, err_set, ovf_nxt;

  assign fire    = en & act_in.valid & w_in.valid;
  assign capture = fire & last_in;

  always_comb begin
    ax       = {{DATA_W{SIGNED & act_in.data[DATA_W-1]}}, act_in.data};
    wx       = {{DATA_W{SIGNED & w_in.data[DATA_W-1]}}, w_in.data};
    prod     = ax * wx;
    prod_ext = ACC_W'(prod) |
               ((SIGNED & prod[2*DATA_W-1]) ? ({ACC_W{1'b1}} << (2*DATA_W)) : '0);
    base     = first_in ? '0 : acc;
    sum      = {1'b0, base} + {1'b0, prod_ext};
    acc_nxt  = sum[ACC_W-1:0];
    if (SIGNED)
      acc_ovf = (base[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_nxt[ACC_W-1] != base[ACC_W-1]);
    else
      acc_ovf = sum[ACC_W];
  end

  pe_requant #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .SIGNED(SIGNED)
  ) u_requant (
    .acc(acc_nxt),
    .q  (q),
    .sat(sat)
  );

  always_comb begin
    state_nxt = state;
    if (fire) begin
      if (last_in)
        state_nxt = ST_IDLE;
      else if (first_in || state == ST_ACC)
        state_nxt = ST_ACC;
    end
  end

  // Overwriting an undrained result counts as an overflow.
  assign ovf_nxt = (first_in ? 1'b0 : ovf) | acc_ovf | (last_in & (sat | (held_v & ~drain)));
  assign err_set = (act_in.valid != w_in.valid) | (fire & (state == ST_IDLE) & ~first_in);
  assign sh      = drain ? held   : res_in.data;
  assign sh_v    = drain ? held_v : res_in.valid;
  assign done    = done_q & en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      acc           <= '0;
      held          <= '0;
      held_v        <= 1'b0;
      done_q        <= 1'b0;
      ovf           <= 1'b0;
      err           <= 1'b0;
      act_out.data  <= '0;
      act_out.valid <= 1'b0;
      first_out     <= 1'b0;
      last_out      <= 1'b0;
      w_out.data    <= '0;
      w_out.valid   <= 1'b0;
      res_out.data  <= '0;
      res_out.valid <= 1'b0;
    end else begin
      done_q <= capture;
      if (en) begin
        state         <= state_nxt;
        act_out.data  <= act_in.data;
        act_out.valid <= act_in.valid;
        first_out     <= first_in;
        last_out      <= last_in;
        w_out.data    <= w_in.data;
        w_out.valid   <= w_in.valid;
        res_out.data  <= sh;
        res_out.valid <= sh_v;
        err           <= err | err_set;
        if (fire) begin
          acc <= acc_nxt;
          ovf <= ovf_nxt;
        end
        if (drain)
          held_v <= 1'b0;
        // A capture on the drain edge lands after the old value was taken.
        if (capture) begin
          held   <= q;
          held_v <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_os_q.sv
// Directed bench: a 4-PE unsigned column on a shared drain chain plus one
// signed PE, each scenario checked against hand-computed values.
module tb_pe_os_q;
  import pe_pkg::*;
  localparam int DW = DATA_W_DEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  logic drain = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [DW-1:0] a_d [4];
  logic [DW-1:0] w_d [4];
  logic          a_v [4], w_v [4], fi [4], la [4];
  logic [DW-1:0] ao_d [4], wo_d [4];
  logic          ao_v [4], wo_v [4], fo [4], lo [4], done_o [4], ovf_o [4], err_o [4];
  logic [DW-1:0] r_d [5];
  logic          r_v [5];

  assign r_d[0] = '0;
  assign r_v[0] = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : col
    pe_os_q_if #(.DATA_W(DW)) ai(), ao(), wi(), wo(), ri(), ro();
    assign ai.data    = a_d[g];
    assign ai.valid   = a_v[g];
    assign wi.data    = w_d[g];
    assign wi.valid   = w_v[g];
    assign ri.data    = r_d[g];
    assign ri.valid   = r_v[g];
    assign ao_d[g]    = ao.data;
    assign ao_v[g]    = ao.valid;
    assign wo_d[g]    = wo.data;
    assign wo_v[g]    = wo.valid;
    assign r_d[g+1]   = ro.data;
    assign r_v[g+1]   = ro.valid;
    pe_os_q #(.DATA_W(DW), .FRAC_W(FRAC_W_DEF), .ACC_W(ACC_W_DEF), .SIGNED(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .act_in(ai), .first_in(fi[g]), .last_in(la[g]),
      .act_out(ao), .first_out(fo[g]), .last_out(lo[g]),
      .w_in(wi), .w_out(wo), .drain(drain), .res_in(ri), .res_out(ro),
      .done(done_o[g]), .ovf(ovf_o[g]), .err(err_o[g]));
  end

  logic [DW-1:0] sa_d, sw_d;
  logic          s_v, sfi, sla, sfo, slo, s_done, s_ovf, s_err;
  pe_os_q_if #(.DATA_W(DW)) s_ai(), s_ao(), s_wi(), s_wo(), s_ri(), s_ro();
  assign s_ai.data  = sa_d;
  assign s_ai.valid = s_v;
  assign s_wi.data  = sw_d;
  assign s_wi.valid = s_v;
  assign s_ri.data  = '0;
  assign s_ri.valid = 1'b0;

  pe_os_q #(.DATA_W(DW), .FRAC_W(FRAC_W_DEF), .ACC_W(ACC_W_DEF), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en),
    .act_in(s_ai), .first_in(sfi), .last_in(sla),
    .act_out(s_ao), .first_out(sfo), .last_out(slo),
    .w_in(s_wi), .w_out(s_wo), .drain(drain), .res_in(s_ri), .res_out(s_ro),
    .done(s_done), .ovf(s_ovf), .err(s_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_u(input int k, input logic [DW-1:0] a, input logic [DW-1:0] w,
                       input logic v, input logic f, input logic l);
    a_d[k] = a; w_d[k] = w; a_v[k] = v; w_v[k] = v; fi[k] = f; la[k] = l;
  endtask

  task automatic set_s(input logic [DW-1:0] a, input logic [DW-1:0] w,
                       input logic f, input logic l);
    sa_d = a; sw_d = w; s_v = 1'b1; sfi = f; sla = l;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      a_v[k] = 1'b0; w_v[k] = 1'b0; fi[k] = 1'b0; la[k] = 1'b0;
    end
    s_v = 1'b0; sfi = 1'b0; sla = 1'b0;
  endtask

  task automatic drain_pulse();
    drain = 1'b1;
    tick();
    drain = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({ao_d[3], ao_v[3], wo_d[3], fo[3]} !== '0) begin
      failures++; $display("FAIL rst_fwd got=%h exp=0", {ao_d[3], ao_v[3], wo_d[3], fo[3]});
    end
    checks++;
    if ({done_o[3], ovf_o[3], err_o[3], r_v[4]} !== 4'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=0000", {done_o[3], ovf_o[3], err_o[3], r_v[4]});
    end
    checks++;
    if ({s_done, s_ovf, s_err, s_ro.valid, s_ro.data} !== '0) begin
      failures++; $display("FAIL rst_signed got=%h exp=0", {s_done, s_ovf, s_err, s_ro.valid, s_ro.data});
    end
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_mac();
    set_u(3, 16'h0100, 16'h0200, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (ao_d[3] !== 16'h0100 || ao_v[3] !== 1'b1 || fo[3] !== 1'b1 || lo[3] !== 1'b0) begin
      failures++; $display("FAIL fwd_act got=%h/%b%b%b exp=0100/110", ao_d[3], ao_v[3], fo[3], lo[3]);
    end
    checks++;
    if (wo_d[3] !== 16'h0200 || wo_v[3] !== 1'b1 || done_o[3] !== 1'b0) begin
      failures++; $display("FAIL fwd_w got=%h/%b done=%b exp=0200/1 done=0", wo_d[3], wo_v[3], done_o[3]);
    end
    set_u(3, 16'h0080, 16'h0400, 1'b1, 1'b0, 1'b1);
    tick();
    idle_all();
    checks++;
    if (done_o[3] !== 1'b1 || ovf_o[3] !== 1'b0 || lo[3] !== 1'b1) begin
      failures++; $display("FAIL mac_done got=%b%b%b exp=101", done_o[3], ovf_o[3], lo[3]);
    end
    tick();
    checks++;
    if (done_o[3] !== 1'b0) begin
      failures++; $display("FAIL done_pulse got=%b exp=0", done_o[3]);
    end
    drain_pulse();
    checks++;
    if (r_d[4] !== 16'h0400 || r_v[4] !== 1'b1) begin
      failures++; $display("FAIL mac_held got=%h/%b exp=0400/1", r_d[4], r_v[4]);
    end
    tick();
    checks++;
    if (r_v[4] !== 1'b0 || err_o[3] !== 1'b0) begin
      failures++; $display("FAIL mac_after got=%b err=%b exp=0 err=0", r_v[4], err_o[3]);
    end
  endtask

  task automatic test_rounding();
    logic [DW-1:0] acc_lo [2];
    logic [DW-1:0] exp_q [2];
    acc_lo = '{16'h0180, 16'h017F};
    exp_q  = '{16'h0002, 16'h0001};
    for (int i = 0; i < 2; i++) begin
      set_u(3, acc_lo[i], 16'h0001, 1'b1, 1'b1, 1'b1);
      tick();
      idle_all();
      drain_pulse();
      checks++;
      if (r_d[4] !== exp_q[i] || r_v[4] !== 1'b1) begin
        failures++; $display("FAIL round_%0d got=%h/%b exp=%h/1", i, r_d[4], r_v[4], exp_q[i]);
      end
    end
  endtask

  task automatic test_signed();
    set_s(16'hFE80, 16'h0200, 1'b1, 1'b1);
    tick();
    idle_all();
    checks++;
    if ({s_ao.data, s_ao.valid, s_wo.data, s_wo.valid, sfo, slo} !== {16'hFE80, 1'b1, 16'h0200, 3'b111}) begin
      failures++; $display("FAIL s_fwd got=%h exp=%h", {s_ao.data, s_ao.valid, s_wo.data, s_wo.valid, sfo, slo},
                           {16'hFE80, 1'b1, 16'h0200, 3'b111});
    end
    checks++;
    if (s_done !== 1'b1 || s_ovf !== 1'b0) begin
      failures++; $display("FAIL s_neg_done got=%b%b exp=10", s_done, s_ovf);
    end
    drain_pulse();
    checks++;
    if (s_ro.data !== 16'hFD00 || s_ro.valid !== 1'b1) begin
      failures++; $display("FAIL s_neg_held got=%h/%b exp=fd00/1", s_ro.data, s_ro.valid);
    end
    for (int i = 0; i < 4; i++) begin
      set_s(16'h7FFF, 16'h7FFF, i == 0, i == 3);
      tick();
    end
    idle_all();
    checks++;
    if (s_done !== 1'b1 || s_ovf !== 1'b1 || s_err !== 1'b0) begin
      failures++; $display("FAIL s_sat_flags got=%b%b%b exp=110", s_done, s_ovf, s_err);
    end
    drain_pulse();
    checks++;
    if (s_ro.data !== 16'h7FFF || s_ro.valid !== 1'b1) begin
      failures++; $display("FAIL s_sat_held got=%h/%b exp=7fff/1", s_ro.data, s_ro.valid);
    end
  endtask

  task automatic test_column();
    logic [DW-1:0] exp_col [4];
    int nv;
    exp_col = '{16'h0044, 16'h0033, 16'h0022, 16'h0011};
    nv = 0;
    set_u(0, 16'h0011, 16'h0100, 1'b1, 1'b1, 1'b1);
    set_u(1, 16'h0022, 16'h0100, 1'b1, 1'b1, 1'b1);
    set_u(2, 16'h0033, 16'h0100, 1'b1, 1'b1, 1'b1);
    set_u(3, 16'h0044, 16'h0100, 1'b1, 1'b1, 1'b1);
    tick();
    idle_all();
    checks++;
    if ({done_o[0], done_o[1], done_o[2], done_o[3]} !== 4'b1111) begin
      failures++; $display("FAIL col_done got=%b exp=1111", {done_o[0], done_o[1], done_o[2], done_o[3]});
    end
    tick();
    drain_pulse();
    for (int i = 0; i < 6; i++) begin
      if (r_v[4] === 1'b1) nv++;
      if (i < 4) begin
        checks++;
        if (r_d[4] !== exp_col[i] || r_v[4] !== 1'b1) begin
          failures++; $display("FAIL col_out_%0d got=%h/%b exp=%h/1", i, r_d[4], r_v[4], exp_col[i]);
        end
      end
      tick();
    end
    checks++;
    if (nv != 4) begin
      failures++; $display("FAIL col_valid_cycles got=%0d exp=4", nv);
    end
  endtask

  task automatic test_overlap();
    set_u(3, 16'h0055, 16'h0100, 1'b1, 1'b1, 1'b1);
    tick();
    set_u(3, 16'h0066, 16'h0100, 1'b1, 1'b1, 1'b1);
    drain_pulse();
    idle_all();
    checks++;
    if (r_d[4] !== 16'h0055 || r_v[4] !== 1'b1 || done_o[3] !== 1'b1 || ovf_o[3] !== 1'b0) begin
      failures++; $display("FAIL ovl_old got=%h/%b done=%b ovf=%b exp=0055/1 done=1 ovf=0",
                           r_d[4], r_v[4], done_o[3], ovf_o[3]);
    end
    tick();
    drain_pulse();
    checks++;
    if (r_d[4] !== 16'h0066 || r_v[4] !== 1'b1) begin
      failures++; $display("FAIL ovl_new got=%h/%b exp=0066/1", r_d[4], r_v[4]);
    end
    set_u(3, 16'h0077, 16'h0100, 1'b1, 1'b1, 1'b1);
    tick();
    set_u(3, 16'h0088, 16'h0100, 1'b1, 1'b1, 1'b1);
    tick();
    idle_all();
    checks++;
    if (ovf_o[3] !== 1'b1) begin
      failures++; $display("FAIL overwrite_ovf got=%b exp=1", ovf_o[3]);
    end
    drain_pulse();
    checks++;
    if (r_d[4] !== 16'h0088 || r_v[4] !== 1'b1) begin
      failures++; $display("FAIL overwrite_val got=%h/%b exp=0088/1", r_d[4], r_v[4]);
    end
    tick();
  endtask

  task automatic test_err();
    a_d[2] = 16'h1234; a_v[2] = 1'b1; w_v[2] = 1'b0; fi[2] = 1'b1; la[2] = 1'b1;
    tick();
    idle_all();
    checks++;
    if (err_o[2] !== 1'b1 || done_o[2] !== 1'b0) begin
      failures++; $display("FAIL err_set got=%b done=%b exp=1 done=0", err_o[2], done_o[2]);
    end
    checks++;
    if (ao_d[2] !== 16'h1234 || ao_v[2] !== 1'b1 || wo_v[2] !== 1'b0) begin
      failures++; $display("FAIL err_fwd got=%h/%b w_v=%b exp=1234/1 w_v=0", ao_d[2], ao_v[2], wo_v[2]);
    end
    tick();
    tick();
    checks++;
    if (err_o[2] !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", err_o[2]);
    end
  endtask

  task automatic test_stall();
    set_u(3, 16'h0100, 16'h0100, 1'b1, 1'b1, 1'b0);
    tick();
    en = 1'b0;
    set_u(3, 16'h0200, 16'h0100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ao_d[3] !== 16'h0100 || fo[3] !== 1'b1 || done_o[3] !== 1'b0) begin
        failures++; $display("FAIL stall_%0d got=%h/%b done=%b exp=0100/1 done=0", i, ao_d[3], fo[3], done_o[3]);
      end
    end
    en = 1'b1;
    set_u(3, 16'h0100, 16'h0200, 1'b1, 1'b0, 1'b1);
    tick();
    idle_all();
    checks++;
    if (done_o[3] !== 1'b1) begin
      failures++; $display("FAIL stall_done got=%b exp=1", done_o[3]);
    end
    drain_pulse();
    checks++;
    if (r_d[4] !== 16'h0300 || r_v[4] !== 1'b1) begin
      failures++; $display("FAIL stall_acc got=%h/%b exp=0300/1", r_d[4], r_v[4]);
    end
  endtask

  task automatic test_reset_mid();
    set_u(3, 16'h0100, 16'h0100, 1'b1, 1'b1, 1'b0);
    tick();
    idle_all();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ao_d[3] !== '0 || ao_v[3] !== 1'b0 || fo[3] !== 1'b0) begin
      failures++; $display("FAIL rst_mid_fwd got=%h/%b%b exp=0/00", ao_d[3], ao_v[3], fo[3]);
    end
    checks++;
    if ({err_o[2], ovf_o[3], done_o[3], r_v[4]} !== 4'b0) begin
      failures++; $display("FAIL rst_mid_flags got=%b exp=0000", {err_o[2], ovf_o[3], done_o[3], r_v[4]});
    end
    tick();
    rst_n = 1'b1;
    tick();
    set_u(3, 16'h0100, 16'h0100, 1'b1, 1'b0, 1'b1);
    tick();
    idle_all();
    checks++;
    if (err_o[3] !== 1'b1 || done_o[3] !== 1'b1) begin
      failures++; $display("FAIL idle_nofirst got=err%b done%b exp=err1 done1", err_o[3], done_o[3]);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      a_d[k] = '0; w_d[k] = '0;
    end
    sa_d = '0;
    sw_d = '0;
    idle_all();
    test_reset();
    test_unsigned_mac();
    test_rounding();
    test_signed();
    test_column();
    test_overlap();
    test_err();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_os_q.md
Name: pe_os_q

Overview:
- Parametrised output-stationary systolic processing element; successor of the fixed 16-bit, 36-bit-accumulator PE used in the attention matrix array.
- Adds signed/unsigned mode, first/last framing, and fixed-point requantisation with round and saturate.
- Adds a double-buffered result register drained down the column through a shift chain, so accumulation of tile k+1 overlaps draining of tile k.
- Sits in an N x M grid: activations flow left to right, weights top to bottom, results drain top to bottom.

Parameters:
- DATA_W, 16, width of activation, weight and requantised result.
- FRAC_W, 8, fractional bits of fixed-point operands (fix_DATA_W-FRAC_W_FRAC_W).
- ACC_W, 36, accumulator width; must be >= 2*DATA_W.
- SIGNED, 0, 1 = two's-complement operands and result; 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  clock enable; 0 freezes every register (stall, not clear).
- act_in  in  DATA_W  activation from left neighbour.
- act_valid_in  in  1  act_in valid.
- w_in  in  DATA_W  weight from top neighbour.
- w_valid_in  in  1  w_in valid.
- first_in  in  1  beat starts a new dot product; travels with the activation.
- last_in  in  1  beat ends the dot product; travels with the activation.
- act_out, act_valid_out, first_out, last_out  out  DATA_W,1,1,1  registered copies to right neighbour.
- w_out, w_valid_out  out  DATA_W,1  registered copies to lower neighbour.
- drain  in  1  global pulse: load held result into the drain shift register.
- res_in, res_valid_in  in  DATA_W,1  drain chain from PE above (tie 0 at top row).
- res_out, res_valid_out  out  DATA_W,1  drain chain to PE below.
- done  out  1  one-cycle pulse: new result captured.
- ovf  out  1  sticky: accumulator overflow or requantisation saturation since last first beat.
- err  out  1  sticky: act_valid_in != w_valid_in seen; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): every output, the accumulator, the held result, the held flag and the shift register are 0. The FSM goes to IDLE.
- en=0: all state holds; outputs keep their values. done is forced low.
- Pass-through: the forward path (act/w/valid/first/last) is one register stage when en=1. Invalid beats are forwarded with valid=0; data is still registered.
- Fire: fire = en & act_valid_in & w_valid_in. prod = act_in*w_in, signed or unsigned per SIGNED, 2*DATA_W bits, extended to ACC_W.
- Accumulate on fire: acc <= (first_in ? 0 : acc) + prod. ovf is cleared by first_in, then set on signed/unsigned ACC_W overflow. Acc wraps.
- FSM states:
  - IDLE: waiting for first_in.
  - ACC: accumulating.
  - IDLE->ACC: fire & first_in & !last_in.
  - ACC->ACC: fire & !last_in. A first_in here restarts the accumulation and discards the partial sum.
  - IDLE/ACC->IDLE with capture: fire & last_in.
  - A fire without first_in in IDLE accumulates onto the stale acc and sets err.
- Capture (on the last beat, same edge): q = (acc_next + 2^(FRAC_W-1)) >>> FRAC_W (round half up). Saturate q to the DATA_W range (signed or unsigned); saturation sets ovf. Store q in held and set held_v.
  - done pulses the cycle after the last beat, so latency is 1 cycle from the last beat to done and held valid.
  - A single-beat product (first&last) is legal.
- Drain chain: every en cycle, res_out <= sh and res_valid_out <= sh_v.
  - If drain: sh <= held, sh_v <= held_v, held_v <= 0.
  - Else: sh <= res_in, sh_v <= res_valid_in.
  - Row r of an R-row column appears at the bottom R-r cycles after the drain edge; results emerge bottom row first.
- Simultaneous events:
  - drain and capture on the same edge: drain takes the old held; the new capture lands in held with held_v=1.
  - Capture while held_v=1 and no drain: the older result is overwritten and ovf is set.
  - drain with held_v=0 inserts a bubble (sh_v=0).
- Reset mid-operation clears everything immediately; in-flight chain data is lost.

Decomposition:
- Shared package pe_pkg: default DATA_W/FRAC_W/ACC_W constants, FSM state enum (ST_IDLE, ST_ACC), and a function sat_round(acc, SIGNED) returning DATA_W bits plus a saturate flag.
- One natural sub-module, pe_requant: combinational round and saturate, reused by the array-edge output stage.
- The FSM, MAC and drain chain stay in pe_os_q.

Test Plan:
- Unsigned, FRAC_W=8: beats (1.0,2.0),(0.5,4.0) i.e. 0x0100*0x0200, 0x0080*0x0400, first then last -> done at last+1; held=0x0400 (4.0); ovf=0.
- SIGNED=1: (-1.5)*(2.0) single beat first&last -> held=0xFD00. Then 0x7FFF*0x7FFF ×4 -> held=0x7FFF, ovf=1.
- Rounding: acc=0x0000_0180 with last -> q=0x0002. Next case: acc=0x0000_017F -> q=0x0001.
- 4-PE column, distinct results 0x0011..0x0044 captured, drain pulse -> bottom res_out shows 0x0044,0x0033,0x0022,0x0011 on cycles 1-4 after drain, valid high exactly 4 cycles.
- Overlap: drain on the same edge as a new last beat -> old value drains; new value held with held_v=1. A second drain emits the new value.
- act_valid_in=1, w_valid_in=0 -> no accumulate, err=1 sticky. en=0 for 3 cycles mid-ACC -> acc and outputs unchanged. rst_n low mid-ACC -> all outputs 0 asynchronously.
